// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message-schedule expander streaming W0..W63
//
// Optional feature macro: SHA256_SCHED_RAM_EN
//   defined   : every streamed word is kept in a 64x32 array readable via RD_IDX/RD_DATA
//   undefined : no array, RD_DATA reads 0 and RD_IDX is ignored

module sha256_msg_schedule (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [511:0] BLOCK_IN,
    output logic         BUSY,
    output logic         W_VALID,
    output logic [5:0]   W_IDX,
    output logic [31:0]  W_OUT,
    output logic         DONE,
    input  logic [5:0]   RD_IDX,
    output logic [31:0]  RD_DATA
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  lo_q, lo_d;
    logic [3:0]  hi_q, hi_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    logic [5:0]  idx;
    logic        last;
    logic        run;
    logic [31:0] w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // The two nibble counters together form the round index; it tops out at 63.
    assign idx  = {hi_q[1:0], lo_q};
    assign last = (idx == 6'd63);
    assign run  = (state_q == S_RUN);

    // win[0] holds Wt, so the word entering at the top is W(t+16).
    assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    // Next-state, counter and window update.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                lo_d = 4'd0;
                hi_d = 4'd0;
                if (START) begin
                    state_d = S_RUN;
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = BLOCK_IN[511 - 32*i -: 32];
                    end
                end
            end
            S_RUN: begin
                if (last) begin
                    // Window is frozen so W_OUT keeps showing W63 once idle.
                    state_d = S_IDLE;
                    lo_d    = 4'd0;
                    hi_d    = 4'd0;
                end else begin
                    lo_d = lo_q + 4'd1;
                    if (lo_q == 4'hf) begin
                        hi_d = hi_q + 4'd1;
                    end
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and window registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            lo_q    <= 4'd0;
            hi_q    <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Stream outputs come straight from the registered state, giving W0 one cycle after START.
    assign BUSY    = run;
    assign W_VALID = run;
    assign W_IDX   = run ? idx : 6'd0;
    assign W_OUT   = win_q[0];
    assign DONE    = run && last;

`ifdef SHA256_SCHED_RAM_EN
    logic [31:0] mem_q [64];
    logic [31:0] mem_d [64];

    // Capture each streamed word at its index; a fresh START wipes the previous block.
    always_comb begin
        mem_d = mem_q;
        if ((state_q == S_IDLE) && START) begin
            for (int i = 0; i < 64; i++) begin
                mem_d[i] = 32'd0;
            end
        end else if (run) begin
            mem_d[idx] = win_q[0];
        end
    end

    // Schedule storage registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign RD_DATA = mem_q[RD_IDX];
`else
    logic [5:0] rd_idx_unused;

    assign rd_idx_unused = RD_IDX;
    assign RD_DATA       = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule

module tb_sha256_msg_schedule;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [511:0] BLOCK_IN;
    logic         BUSY;
    logic         W_VALID;
    logic [5:0]   W_IDX;
    logic [31:0]  W_OUT;
    logic         DONE;
    logic [5:0]   RD_IDX;
    logic [31:0]  RD_DATA;

    int total;
    int bad;

    logic [31:0] ref_w [64];
    logic [31:0] got   [64];

    typedef struct {
        string        name;
        logic [511:0] blk;
        int           idx;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [8];

    sha256_msg_schedule dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .BLOCK_IN (BLOCK_IN),
        .BUSY     (BUSY),
        .W_VALID  (W_VALID),
        .W_IDX    (W_IDX),
        .W_OUT    (W_OUT),
        .DONE     (DONE),
        .RD_IDX   (RD_IDX),
        .RD_DATA  (RD_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the FIPS recurrence over a plain array.
    task automatic build_ref(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) begin
            ref_w[t] = blk[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
        end
    endtask

    // Called at a negedge; raises START immediately and checks every streamed cycle.
    task automatic stream(input logic [511:0] blk, input int restart_t, input int abort_t);
        build_ref(blk);
        BLOCK_IN = blk;
        START    = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
        for (int t = 0; t < 64; t++) begin
            check($sformatf("w_valid t=%0d", t), {31'd0, W_VALID}, 32'd1);
            check($sformatf("busy t=%0d", t), {31'd0, BUSY}, 32'd1);
            check($sformatf("w_idx t=%0d", t), {26'd0, W_IDX}, t);
            check($sformatf("done t=%0d", t), {31'd0, DONE}, {31'd0, (t == 63)});
            check($sformatf("w_out t=%0d", t), W_OUT, ref_w[t]);
            got[t] = W_OUT;
            if (t == abort_t) begin
                RST_N = 1'b0;
                #1;
                check("abort busy", {31'd0, BUSY}, 32'd0);
                check("abort w_valid", {31'd0, W_VALID}, 32'd0);
                check("abort done", {31'd0, DONE}, 32'd0);
                check("abort w_idx", {26'd0, W_IDX}, 32'd0);
                check("abort w_out", W_OUT, 32'd0);
                @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            if (t == restart_t) begin
                START    = 1'b1;
                BLOCK_IN = ~blk;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check("post w_valid", {31'd0, W_VALID}, 32'd0);
        check("post busy", {31'd0, BUSY}, 32'd0);
        check("post done", {31'd0, DONE}, 32'd0);
        check("post w_out hold", W_OUT, ref_w[63]);
    endtask

    initial begin
        logic [511:0] abc_blk;
        logic [511:0] rblk;

        total    = 0;
        bad      = 0;
        RST_N    = 1'b0;
        START    = 1'b0;
        BLOCK_IN = '0;
        RD_IDX   = 6'd17;

        abc_blk = {32'h61626380, 448'd0, 32'h00000018};

        vecs[0] = '{"zero w63",  512'd0,            63, 32'h00000000};
        vecs[1] = '{"zero w40",  512'd0,            40, 32'h00000000};
        vecs[2] = '{"w0 w16",    512'd1 << 480,     16, 32'h00000001};
        vecs[3] = '{"w0 w17",    512'd1 << 480,     17, 32'h00000000};
        vecs[4] = '{"w0 w18",    512'd1 << 480,     18, 32'h0000a000};
        vecs[5] = '{"w1 w16",    512'd1 << 448,     16, 32'h02004000};
        vecs[6] = '{"abc w16",   abc_blk,           16, 32'h61626380};
        vecs[7] = '{"abc w17",   abc_blk,           17, 32'h000f0000};

        #23;
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset w_valid", {31'd0, W_VALID}, 32'd0);
        check("reset done", {31'd0, DONE}, 32'd0);
        check("reset w_idx", {26'd0, W_IDX}, 32'd0);
        check("reset w_out", W_OUT, 32'd0);
        check("reset rd_data", RD_DATA, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 8; v++) begin
            stream(vecs[v].blk, -1, -1);
            check(vecs[v].name, got[vecs[v].idx], vecs[v].exp);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                rblk[511 - 32*i -: 32] = $urandom;
            end
            stream(rblk, -1, -1);
        end

        // Back-to-back: second START lands on the first idle cycle.
        stream(abc_blk, -1, -1);
        stream(abc_blk, -1, -1);

`ifdef SHA256_SCHED_RAM_EN
        RD_IDX = 6'd17;
        #1;
        check("ram rd 17", RD_DATA, 32'h000f0000);
        RD_IDX = 6'd0;
        #1;
        check("ram rd 0", RD_DATA, 32'h61626380);
        RD_IDX = 6'd63;
        #1;
        check("ram rd 63", RD_DATA, ref_w[63]);
`else
        RD_IDX = 6'd17;
        #1;
        check("no ram rd_data", RD_DATA, 32'd0);
`endif
        @(negedge CLK);

        for (int i = 0; i < 16; i++) begin
            rblk[511 - 32*i -: 32] = $urandom;
        end
        stream(rblk, 20, -1);
        stream(rblk, -1, 30);
        stream(abc_blk, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule expander. Captures one 512-bit padded block (W0..W15) and streams all 64 schedule words W0..W63, one per clock.
- Computes Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16 for t ≥ 16.
- Sits between the block padder and the compression round engine.
- Round index comes from an internal 8-bit counter built as two cascaded 4-bit nibble counters (dual-4-bit-counter style).

Parameters:
- None. Word width is fixed at 32 and round count at 64.

Ports:
- CLK  input  1  rising-edge clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request; captures BLOCK_IN when idle.
- BLOCK_IN  input  512  padded block; W0 = bits [511:480], W15 = bits [31:0].
- BUSY  output  1  high while words are being streamed.
- W_VALID  output  1  W_OUT/W_IDX hold schedule word Wt.
- W_IDX  output  6  index t of the word on W_OUT.
- W_OUT  output  32  schedule word Wt.
- DONE  output  1  one-cycle pulse coincident with t = 63.
- RD_IDX  input  6  random-access read index (optional feature).
- RD_DATA  output  32  random-access read data (optional feature).

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; counter = 0; window cleared; BUSY, W_VALID, DONE, W_IDX, W_OUT all 0.
- States:
  - IDLE: counter held cleared. START=1 loads the 16-word window from BLOCK_IN and goes to RUN.
  - RUN: one word is output per cycle.
  - RUN → IDLE after the t = 63 cycle.
- Latency: the first valid word (W0) appears on the cycle after the START edge. Wt is valid on cycle t+1 after START, so 64 consecutive W_VALID cycles.
- Window: 16×32 shift register win[0..15]. Each RUN cycle:
  - W_OUT ← win[0], W_IDX ← counter, W_VALID ← 1.
  - win shifts down by one.
  - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0].
  - All additions are modulo 2^32; carries are discarded.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). Both purely combinational.
- Counter:
  - Low nibble increments every RUN cycle; its wrap 15→0 increments the high nibble.
  - Index = {high, low}[5:0].
  - Synchronous clear in IDLE; never exceeds 63.
- BUSY: high on every RUN cycle, including the t = 63 cycle.
- DONE: high only in the t = 63 cycle.
- The cycle after the t = 63 cycle: W_VALID = 0, BUSY = 0, and W_OUT holds the last word.
- START while BUSY: ignored; the current stream is unaffected.
- START on the cycle the FSM returns to IDLE: accepted.
- Reset mid-stream: immediate abort; outputs return to reset values; no DONE pulse.

Optional Feature:
- Macro: SHA256_SCHED_RAM_EN.
- Defined:
  - 64×32 array stores every streamed Wt at index t.
  - RD_DATA = stored[RD_IDX], combinational read.
  - Array is cleared by reset and cleared on START.
  - Reading an index not yet written returns 0.
- Undefined: no array; RD_DATA tied to 0; RD_IDX unused.

Test Plan:
- All-zero BLOCK_IN, START → 64 W_VALID cycles, every W_OUT = 0, W_IDX 0..63, DONE only at W_IDX = 63.
- Only W0 = 0x00000001 → W16 = 0x00000001, W17 = 0x00000000, W18 = 0x0000A000 (exercises σ1).
- Only W1 = 0x00000001 → W16 = 0x02004000 (exercises σ0).
- "abc" block (W0 = 0x61626380, W15 = 0x00000018, rest 0):
  - W16 = 0x61626380, W17 = 0x000F0000.
  - W63 matches the FIPS 180-4 reference schedule value.
- START pulsed again at t = 20 → ignored; stream continues unchanged. RST_N low at t = 30 → BUSY, W_VALID, DONE = 0 immediately; a new START afterwards restarts at W0.
- With SHA256_SCHED_RAM_EN defined, after "abc" DONE → RD_IDX = 17 gives 0x000F0000 and RD_IDX = 0 gives 0x61626380. Without the macro, RD_DATA = 0.
